// File: rtl/pr_dma_wr_arbiter.sv
// Burst-locked round-robin arbiter for the PR slot DMA command-write channel, with quiesce handshake.
// Optional stall watchdog is compiled in when PR_ARB_WDOG_EN is defined.
module pr_dma_wr_arbiter #(
  parameter int PORT_COUNT  = 2,
  parameter int DATA_WIDTH  = 128,
  parameter int STRB_WIDTH  = 16,
  parameter int WDOG_CYCLES = 1024,
  localparam int GW = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [PORT_COUNT-1:0]            s_wr_en,
  input  logic [PORT_COUNT*26-1:0]         s_wr_addr,
  input  logic [PORT_COUNT-1:0]            s_wr_hdr_en,
  input  logic [PORT_COUNT*24-1:0]         s_wr_hdr_addr,
  input  logic [PORT_COUNT*DATA_WIDTH-1:0] s_wr_data,
  input  logic [PORT_COUNT*STRB_WIDTH-1:0] s_wr_strb,
  input  logic [PORT_COUNT-1:0]            s_wr_last,
  output logic [PORT_COUNT-1:0]            s_wr_ready,
  output logic                             m_wr_en,
  output logic [25:0]                      m_wr_addr,
  output logic                             m_wr_hdr_en,
  output logic [23:0]                      m_wr_hdr_addr,
  output logic [DATA_WIDTH-1:0]            m_wr_data,
  output logic [STRB_WIDTH-1:0]            m_wr_strb,
  output logic                             m_wr_last,
  input  logic                             m_wr_ready,
  input  logic                             quiesce_req,
  output logic                             quiesce_ack,
  output logic [GW-1:0]                    grant_id,
  output logic                             wdog_err,
  output logic [1:0]                       state_dbg
);

  // Handshake: a beat moves when en && ready are both high on a clock edge. The granted
  // port sees ready = m_wr_ready combinationally; every other port sees ready = 0.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BURST    = 2'd1,
    ST_QUIESCED = 2'd2
  } state_t;

  localparam int AW = 26;
  localparam int HW = 24;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   rr_q, rr_d;
  logic [GW-1:0]   pick;
  logic [GW-1:0]   next_port;
  logic            req_any;
  logic            xfer;
  logic            wdog_timeout;
  int              arb_idx;

  logic [AW-1:0]         addr_a     [PORT_COUNT];
  logic [HW-1:0]         hdr_addr_a [PORT_COUNT];
  logic [DATA_WIDTH-1:0] data_a     [PORT_COUNT];
  logic [STRB_WIDTH-1:0] strb_a     [PORT_COUNT];

  for (genvar i = 0; i < PORT_COUNT; i++) begin : g_unpack
    assign addr_a[i]     = s_wr_addr[i*AW +: AW];
    assign hdr_addr_a[i] = s_wr_hdr_addr[i*HW +: HW];
    assign data_a[i]     = s_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
    assign strb_a[i]     = s_wr_strb[i*STRB_WIDTH +: STRB_WIDTH];
  end

  // Lowest offset from the rr pointer wins; the loop runs high-to-low so it lands last.
  always_comb begin
    pick    = rr_q;
    req_any = 1'b0;
    arb_idx = 0;
    for (int i = PORT_COUNT - 1; i >= 0; i--) begin
      arb_idx = int'(rr_q) + i;
      if (arb_idx >= PORT_COUNT) arb_idx = arb_idx - PORT_COUNT;
      if (s_wr_en[GW'(arb_idx)]) begin
        pick    = GW'(arb_idx);
        req_any = 1'b1;
      end
    end
  end

  assign next_port = (grant_q == GW'(PORT_COUNT - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    m_wr_en       = 1'b0;
    m_wr_addr     = '0;
    m_wr_hdr_en   = 1'b0;
    m_wr_hdr_addr = '0;
    m_wr_data     = '0;
    m_wr_strb     = '0;
    m_wr_last     = 1'b0;
    s_wr_ready    = '0;
    if (state_q == ST_BURST) begin
      m_wr_en              = s_wr_en[grant_q];
      m_wr_addr            = addr_a[grant_q];
      m_wr_hdr_en          = s_wr_hdr_en[grant_q];
      m_wr_hdr_addr        = hdr_addr_a[grant_q];
      m_wr_data            = data_a[grant_q];
      m_wr_strb            = strb_a[grant_q];
      m_wr_last            = s_wr_last[grant_q];
      s_wr_ready[grant_q]  = m_wr_ready;
    end
  end

  assign xfer = m_wr_en && m_wr_ready;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    case (state_q)
      ST_IDLE: begin
        if (quiesce_req) begin
          state_d = ST_QUIESCED;
        end else if (req_any) begin
          grant_d = pick;
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        if (xfer && m_wr_last) begin
          rr_d    = next_port;
          state_d = quiesce_req ? ST_QUIESCED : ST_IDLE;
        end else if (wdog_timeout) begin
          rr_d    = next_port;
          state_d = ST_IDLE;
        end
      end
      ST_QUIESCED: begin
        if (!quiesce_req) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

  assign quiesce_ack = (state_q == ST_QUIESCED);
  assign grant_id    = grant_q;
  assign state_dbg   = state_q;

`ifdef PR_ARB_WDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);

  logic [WW-1:0] wdog_cnt_q;
  logic          wdog_err_q;

  // Any cycle in BURST without a beat moving counts as a stall, whoever is at fault.
  assign wdog_timeout = (state_q == ST_BURST) && !xfer && (wdog_cnt_q == WW'(WDOG_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      if ((state_q != ST_BURST) || xfer || wdog_timeout) wdog_cnt_q <= '0;
      else                                               wdog_cnt_q <= wdog_cnt_q + 1'b1;
      if (wdog_timeout) wdog_err_q <= 1'b1;
    end
  end

  assign wdog_err = wdog_err_q;
`else
  assign wdog_timeout = 1'b0;
  assign wdog_err     = 1'b0;
`endif

endmodule

// File: tb/tb_pr_dma_wr_arbiter.sv
// Bench for pr_dma_wr_arbiter: per-port beat sources, a scoreboard on the master side,
// and directed scenarios for timing, fairness, quiesce, reset and the optional watchdog.
module tb_pr_dma_wr_arbiter;

  localparam int PC = 2;
  localparam int DW = 128;
  localparam int SW = 16;
  localparam int WD = 16;
  localparam int BW = 196;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [PC-1:0]    s_wr_en = '0;
  logic [PC*26-1:0] s_wr_addr = '0;
  logic [PC-1:0]    s_wr_hdr_en = '0;
  logic [PC*24-1:0] s_wr_hdr_addr = '0;
  logic [PC*DW-1:0] s_wr_data = '0;
  logic [PC*SW-1:0] s_wr_strb = '0;
  logic [PC-1:0]    s_wr_last = '0;
  logic [PC-1:0]    s_wr_ready;
  logic             m_wr_en;
  logic [25:0]      m_wr_addr;
  logic             m_wr_hdr_en;
  logic [23:0]      m_wr_hdr_addr;
  logic [DW-1:0]    m_wr_data;
  logic [SW-1:0]    m_wr_strb;
  logic             m_wr_last;
  logic             m_wr_ready = 1'b0;
  logic             quiesce_req = 1'b0;
  logic             quiesce_ack;
  logic [0:0]       grant_id;
  logic             wdog_err;
  logic [1:0]       state_dbg;

  pr_dma_wr_arbiter #(
    .PORT_COUNT(PC), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .WDOG_CYCLES(WD)
  ) dut (
    .clk(clk), .rst(rst),
    .s_wr_en(s_wr_en), .s_wr_addr(s_wr_addr), .s_wr_hdr_en(s_wr_hdr_en),
    .s_wr_hdr_addr(s_wr_hdr_addr), .s_wr_data(s_wr_data), .s_wr_strb(s_wr_strb),
    .s_wr_last(s_wr_last), .s_wr_ready(s_wr_ready),
    .m_wr_en(m_wr_en), .m_wr_addr(m_wr_addr), .m_wr_hdr_en(m_wr_hdr_en),
    .m_wr_hdr_addr(m_wr_hdr_addr), .m_wr_data(m_wr_data), .m_wr_strb(m_wr_strb),
    .m_wr_last(m_wr_last), .m_wr_ready(m_wr_ready),
    .quiesce_req(quiesce_req), .quiesce_ack(quiesce_ack), .grant_id(grant_id),
    .wdog_err(wdog_err), .state_dbg(state_dbg)
  );

  // beat layout: {addr[25:0], hdr_en, hdr_addr[23:0], data[127:0], strb[15:0], last}
  logic [BW-1:0] exp_q0[$];
  logic [BW-1:0] exp_q1[$];

  int n_checks = 0;
  int n_fail   = 0;
  int ready_pct = 100;
  int gap_max   = 0;
  int hold[2]   = '{0, 0};
  bit popped[2] = '{1'b0, 1'b0};
  int xfer_cnt[2] = '{0, 0};
  int burst_log[$];

  // scoreboard state
  bit            sb_in_burst = 1'b0;
  bit            sb_owner = 1'b0;
  bit            sb_must_valid = 1'b0;
  bit            sb_must_owner = 1'b0;
  bit            sb_p;
  logic [1:0]    sb_acc;
  logic          sb_xf;
  logic [BW-1:0] sb_exp;
  logic [BW-1:0] sb_obs;

  function automatic int qsize(bit p);
    return p ? exp_q1.size() : exp_q0.size();
  endfunction

  function automatic logic [BW-1:0] qhead(bit p);
    return p ? exp_q1[0] : exp_q0[0];
  endfunction

  function automatic logic [BW-1:0] mk_beat(bit hdr, bit last);
    logic [BW-1:0] b;
    b[195:170] = 26'($urandom);
    b[169]     = hdr;
    b[168:145] = 24'($urandom);
    b[144:17]  = {$urandom, $urandom, $urandom, $urandom};
    b[16:1]    = 16'($urandom);
    b[0]       = last;
    return b;
  endfunction

  task automatic push_burst(input bit p, input int len, input bit hdr);
    for (int i = 0; i < len; i++) begin
      if (p) exp_q1.push_back(mk_beat(hdr, i == len - 1));
      else   exp_q0.push_back(mk_beat(hdr, i == len - 1));
    end
  endtask

  task automatic present(input bit p, input logic [BW-1:0] b);
    s_wr_en[p]     = 1'b1;
    s_wr_hdr_en[p] = b[169];
    s_wr_last[p]   = b[0];
    if (p) begin
      s_wr_addr[51:26]     = b[195:170];
      s_wr_hdr_addr[47:24] = b[168:145];
      s_wr_data[255:128]   = b[144:17];
      s_wr_strb[31:16]     = b[16:1];
    end else begin
      s_wr_addr[25:0]      = b[195:170];
      s_wr_hdr_addr[23:0]  = b[168:145];
      s_wr_data[127:0]     = b[144:17];
      s_wr_strb[15:0]      = b[16:1];
    end
  endtask

  // driver: a presented beat stays valid until accepted; random gap before the next one
  task automatic drive_port(input bit p);
    if (popped[p]) begin
      popped[p] = 1'b0;
      hold[p]   = $urandom_range(0, gap_max);
    end
    if (qsize(p) != 0 && hold[p] == 0) begin
      present(p, qhead(p));
    end else begin
      s_wr_en[p] = 1'b0;
      if (hold[p] > 0) hold[p]--;
    end
  endtask

  task automatic drive_loop();
    forever begin
      @(posedge clk);
      #1;
      drive_port(1'b0);
      drive_port(1'b1);
      m_wr_ready = ($urandom_range(0, 99) < ready_pct);
    end
  endtask

  // scoreboard: each accepted beat must equal the head of its source queue, bursts never
  // interleave, and a port left waiting at the end of a burst gets the next grant
  task automatic sb_loop();
    forever begin
      @(negedge clk);
      if (rst) begin
        sb_in_burst   = 1'b0;
        sb_must_valid = 1'b0;
      end else begin
        sb_acc = s_wr_ready & s_wr_en;
        sb_xf  = m_wr_en & m_wr_ready;
        n_checks++;
        if ((sb_xf !== (sb_acc != 2'b00)) || ($countones(sb_acc) > 1)) begin
          n_fail++;
          $display("FAIL handshake: m_xfer=%b s_accept=%b (need one accept per master beat)", sb_xf, sb_acc);
        end else if (sb_xf) begin
          sb_p = sb_acc[1];
          n_checks++;
          if (qsize(sb_p) == 0) begin
            n_fail++;
            $display("FAIL spurious_beat: port %0d accepted with empty source", sb_p);
          end else begin
            sb_exp = qhead(sb_p);
            sb_obs = {m_wr_addr, m_wr_hdr_en, m_wr_hdr_addr, m_wr_data, m_wr_strb, m_wr_last};
            if (sb_obs !== sb_exp) begin
              n_fail++;
              $display("FAIL beat_data: port %0d got %h expected %h", sb_p, sb_obs, sb_exp);
            end
            if (sb_p) void'(exp_q1.pop_front());
            else      void'(exp_q0.pop_front());
            popped[sb_p] = 1'b1;
            xfer_cnt[sb_p]++;
            if (!sb_in_burst) begin
              burst_log.push_back(int'(sb_p));
              if (sb_must_valid) begin
                n_checks++;
                if (sb_p != sb_must_owner) begin
                  n_fail++;
                  $display("FAIL rr_order: burst from port %0d, expected port %0d", sb_p, sb_must_owner);
                end
                sb_must_valid = 1'b0;
              end
              sb_owner    = sb_p;
              sb_in_burst = 1'b1;
            end else begin
              n_checks++;
              if (sb_p != sb_owner) begin
                n_fail++;
                $display("FAIL interleave: beat from port %0d inside burst of port %0d", sb_p, sb_owner);
              end
            end
            if (sb_exp[0]) begin
              sb_in_burst   = 1'b0;
              sb_must_valid = s_wr_en[~sb_p];
              sb_must_owner = ~sb_p;
            end
          end
        end
      end
    end
  endtask

  task automatic timeout_guard();
    #10ms;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    int c = 0;
    while ((qsize(1'b0) != 0 || qsize(1'b1) != 0 || sb_in_burst) && c < budget) begin
      tick();
      c++;
    end
    n_checks++;
    if (c >= budget) begin
      n_fail++;
      $display("FAIL drain_timeout: q0=%0d q1=%0d beats left after %0d cycles", exp_q0.size(), exp_q1.size(), c);
    end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    push_burst(1'b1, 1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (m_wr_en !== 1'b0 || s_wr_ready !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_quiet: m_wr_en=%b s_wr_ready=%b, required 0/00", m_wr_en, s_wr_ready);
      end
    end
    n_checks++;
    if (quiesce_ack !== 1'b0 || grant_id !== 1'b0 || wdog_err !== 1'b0 ||
        state_dbg !== 2'd0 || m_wr_data !== '0 || m_wr_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: ack=%b grant=%b wdog=%b state=%0d data=%h last=%b, required all 0",
               quiesce_ack, grant_id, wdog_err, state_dbg, m_wr_data, m_wr_last);
    end
    rst = 1'b0;
    wait_drain(50);
  endtask

  task automatic test_single_burst();
    logic [BW-1:0] beats[4];
    bit exp_en;
    ready_pct = 100;
    gap_max   = 0;
    for (int i = 0; i < 4; i++) beats[i] = mk_beat(1'b0, i == 3);
    for (int i = 0; i < 4; i++) exp_q0.push_back(beats[i]);
    for (int k = 0; k < 6; k++) begin
      tick();
      exp_en = (k >= 1 && k <= 4);
      n_checks++;
      if (m_wr_en !== exp_en) begin
        n_fail++;
        $display("FAIL single_en: cycle %0d m_wr_en=%b required %b", k, m_wr_en, exp_en);
      end
      if (exp_en) begin
        n_checks++;
        if (m_wr_data !== beats[k-1][144:17] || grant_id !== 1'b0) begin
          n_fail++;
          $display("FAIL single_data: beat %0d data=%h grant=%b required %h grant 0",
                   k - 1, m_wr_data, grant_id, beats[k-1][144:17]);
        end
      end
    end
    n_checks++;
    if (state_dbg !== 2'd0) begin
      n_fail++;
      $display("FAIL single_idle: state=%0d required 0 after last beat", state_dbg);
    end
    wait_drain(20);
  endtask

  task automatic test_alternate();
    ready_pct = 100;
    gap_max   = 0;
    burst_log.delete();
    for (int i = 0; i < 4; i++) begin
      push_burst(1'b0, 2, 1'b0);
      push_burst(1'b1, 2, 1'b0);
    end
    wait_drain(200);
    n_checks++;
    if (burst_log.size() != 8) begin
      n_fail++;
      $display("FAIL alt_count: %0d bursts seen, required 8", burst_log.size());
    end else begin
      // rr pointer sits at port 1 after the previous port-0 burst
      n_checks++;
      if (burst_log[0] != 1) begin
        n_fail++;
        $display("FAIL alt_first: first grant port %0d, required 1", burst_log[0]);
      end
      for (int i = 1; i < 8; i++) begin
        n_checks++;
        if (burst_log[i] == burst_log[i-1]) begin
          n_fail++;
          $display("FAIL alt_order: burst %0d port %0d repeats previous", i, burst_log[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int base;
    int c = 0;
    ready_pct = 100;
    gap_max   = 0;
    burst_log.delete();
    base = xfer_cnt[1];
    push_burst(1'b1, 5, 1'b0);
    while (xfer_cnt[1] < base + 2 && c < 50) begin
      tick();
      c++;
    end
    push_burst(1'b0, 2, 1'b0);
    wait_drain(100);
    n_checks++;
    if (burst_log.size() != 2 || burst_log[0] != 1 || burst_log[1] != 0) begin
      n_fail++;
      $display("FAIL mid_burst_wait: %0d bursts, order %0d,%0d required port 1 then port 0",
               burst_log.size(), (burst_log.size() > 0) ? burst_log[0] : -1,
               (burst_log.size() > 1) ? burst_log[1] : -1);
    end
  endtask

  task automatic test_quiesce();
    int base;
    int c = 0;
    ready_pct = 100;
    gap_max   = 0;
    quiesce_req = 1'b1;
    tick();
    n_checks++;
    if (quiesce_ack !== 1'b1 || state_dbg !== 2'd2) begin
      n_fail++;
      $display("FAIL quiesce_idle: ack=%b state=%0d required 1/2", quiesce_ack, state_dbg);
    end
    quiesce_req = 1'b0;
    tick();
    n_checks++;
    if (quiesce_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL quiesce_release: ack=%b required 0", quiesce_ack);
    end
    base = xfer_cnt[0];
    push_burst(1'b0, 3, 1'b0);
    while (xfer_cnt[0] < base + 1 && c < 20) begin
      tick();
      c++;
    end
    quiesce_req = 1'b1;
    while (xfer_cnt[0] < base + 3 && c < 40) begin
      n_checks++;
      if (quiesce_ack !== 1'b0) begin
        n_fail++;
        $display("FAIL quiesce_early: ack=%b during burst, required 0", quiesce_ack);
      end
      tick();
      c++;
    end
    tick();
    n_checks++;
    if (quiesce_ack !== 1'b1 || m_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL quiesce_after_last: ack=%b m_wr_en=%b required 1/0", quiesce_ack, m_wr_en);
    end
    push_burst(1'b1, 2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (quiesce_ack !== 1'b1 || m_wr_en !== 1'b0 || s_wr_ready !== 2'b00) begin
        n_fail++;
        $display("FAIL quiesce_hold: ack=%b m_wr_en=%b ready=%b required 1/0/00",
                 quiesce_ack, m_wr_en, s_wr_ready);
      end
    end
    quiesce_req = 1'b0;
    tick();
    n_checks++;
    if (quiesce_ack !== 1'b0 || m_wr_en !== 1'b0 || state_dbg !== 2'd0) begin
      n_fail++;
      $display("FAIL quiesce_exit: ack=%b m_wr_en=%b state=%0d required 0/0/0",
               quiesce_ack, m_wr_en, state_dbg);
    end
    tick();
    n_checks++;
    if (m_wr_en !== 1'b1 || grant_id !== 1'b1) begin
      n_fail++;
      $display("FAIL quiesce_regrant: m_wr_en=%b grant=%b required 1/1", m_wr_en, grant_id);
    end
    wait_drain(50);
  endtask

  task automatic test_reset_mid_burst();
    int base;
    int c = 0;
    ready_pct = 100;
    gap_max   = 0;
    base = xfer_cnt[0];
    push_burst(1'b0, 4, 1'b0);
    while (xfer_cnt[0] < base + 2 && c < 20) begin
      tick();
      c++;
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (m_wr_en !== 1'b0 || s_wr_ready !== 2'b00 || state_dbg !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_mid_burst: m_wr_en=%b ready=%b state=%0d required 0/00/0",
               m_wr_en, s_wr_ready, state_dbg);
    end
    rst = 1'b0;
    wait_drain(50);
  endtask

  task automatic test_random();
    int tot[2] = '{0, 0};
    int base[2];
    int len;
    bit p;
`ifdef PR_ARB_WDOG_EN
    ready_pct = 75;
    gap_max   = 0;
`else
    ready_pct = 50;
    gap_max   = 3;
`endif
    base[0] = xfer_cnt[0];
    base[1] = xfer_cnt[1];
    for (int i = 0; i < 1000; i++) begin
      p = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) begin
        len = 1;
        push_burst(p, 1, 1'b1);
      end else begin
        len = $urandom_range(1, 4);
        push_burst(p, len, 1'b0);
      end
      tot[p] += len;
    end
    wait_drain(60000);
    for (int q = 0; q < 2; q++) begin
      n_checks++;
      if (xfer_cnt[q] - base[q] != tot[q]) begin
        n_fail++;
        $display("FAIL random_count: port %0d moved %0d beats, required %0d", q, xfer_cnt[q] - base[q], tot[q]);
      end
    end
  endtask

  task automatic test_wdog();
`ifdef PR_ARB_WDOG_EN
    int c = 0;
    int stall = 0;
    ready_pct = 0;
    gap_max   = 0;
    push_burst(1'b0, 3, 1'b0);
    while (m_wr_en !== 1'b1 && c < 10) begin
      tick();
      c++;
    end
    push_burst(1'b1, 2, 1'b0);
    c = 0;
    while (wdog_err !== 1'b1 && c < 100) begin
      if (m_wr_en === 1'b1) stall++;
      tick();
      c++;
    end
    n_checks++;
    if (wdog_err !== 1'b1 || stall != WD) begin
      n_fail++;
      $display("FAIL wdog_fire: wdog_err=%b after %0d stalled cycles, required 1 after %0d", wdog_err, stall, WD);
    end
    tick();
    n_checks++;
    if (m_wr_en !== 1'b1 || grant_id !== 1'b1) begin
      n_fail++;
      $display("FAIL wdog_regrant: m_wr_en=%b grant=%b required 1/1", m_wr_en, grant_id);
    end
    ready_pct = 100;
    wait_drain(100);
    n_checks++;
    if (wdog_err !== 1'b1) begin
      n_fail++;
      $display("FAIL wdog_sticky: wdog_err=%b required 1", wdog_err);
    end
`else
    n_checks++;
    if (wdog_err !== 1'b0) begin
      n_fail++;
      $display("FAIL wdog_tied: wdog_err=%b required 0", wdog_err);
    end
`endif
  endtask

  initial begin
    fork
      drive_loop();
      sb_loop();
      timeout_guard();
    join_none
    test_reset();
    test_single_burst();
    test_alternate();
    test_back_to_back();
    test_quiesce();
    test_reset_mid_burst();
    test_random();
    test_wdog();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
